// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: active-low column drive, press/release debounce, one hex code per press.
// Optional `SCAN_SYNC_EN adds a 2-flop row synchronizer; when undefined, rows are used as-is.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned DEB_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_col_idx;
  logic [1:0]       r_row_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  logic [3:0]       w_rows_s;
  logic             w_any_low;
  logic [1:0]       w_low_row;
  logic             w_row_level;
  logic [1:0]       w_col_next;
  logic [3:0]       w_code;

`ifdef SCAN_SYNC_EN
  logic [3:0] r_rows_meta;
  logic [3:0] r_rows_sync;

  // Rows are asynchronous to clk; idle (all high) out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
    end else begin
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
    end
  end

  assign w_rows_s = r_rows_sync;
`else
  assign w_rows_s = rows;
`endif

  assign w_any_low   = ~(&w_rows_s);
  assign w_row_level = w_rows_s[r_row_idx];
  assign w_col_next  = r_col_idx + 2'd1;

  // Lowest-index low row wins when several rows are pulled down.
  always_comb begin
    w_low_row = 2'd3;
    if (!w_rows_s[0])      w_low_row = 2'd0;
    else if (!w_rows_s[1]) w_low_row = 2'd1;
    else if (!w_rows_s[2]) w_low_row = 2'd2;
  end

  always_comb begin
    w_code = 4'h0;
    case ({r_row_idx, r_col_idx})
      4'b00_00: w_code = 4'h1;
      4'b00_01: w_code = 4'h2;
      4'b00_10: w_code = 4'h3;
      4'b00_11: w_code = 4'hA;
      4'b01_00: w_code = 4'h4;
      4'b01_01: w_code = 4'h5;
      4'b01_10: w_code = 4'h6;
      4'b01_11: w_code = 4'hB;
      4'b10_00: w_code = 4'h7;
      4'b10_01: w_code = 4'h8;
      4'b10_10: w_code = 4'h9;
      4'b10_11: w_code = 4'hC;
      4'b11_00: w_code = 4'hE;
      4'b11_01: w_code = 4'h0;
      4'b11_10: w_code = 4'hF;
      4'b11_11: w_code = 4'hD;
      default:  w_code = 4'h0;
    endcase
  end

  // The shared counter is the column dwell in SCAN and the debounce timer elsewhere.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_SCAN;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_cnt       <= '0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_cnt == SCAN_LAST) begin
            r_cnt <= '0;
            if (w_any_low) begin
              r_row_idx <= w_low_row;
              r_state   <= ST_DEB_PRESS;
            end else begin
              r_col_idx <= w_col_next;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DEB_PRESS: begin
          if (r_cnt == DEB_LAST) begin
            r_cnt <= '0;
            if (!w_row_level) begin
              r_state     <= ST_HELD;
              r_key_code  <= w_code;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
            end else begin
              r_state   <= ST_SCAN;
              r_col_idx <= w_col_next;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (w_row_level) begin
            r_state <= ST_DEB_RELEASE;
            r_cnt   <= '0;
          end
        end
        ST_DEB_RELEASE: begin
          if (r_cnt == DEB_LAST) begin
            r_cnt <= '0;
            if (w_row_level) begin
              r_state    <= ST_SCAN;
              r_col_idx  <= w_col_next;
              r_key_held <= 1'b0;
            end else begin
              r_state <= ST_HELD;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_SCAN;
          r_cnt      <= '0;
          r_key_held <= 1'b0;
        end
      endcase
    end
  end

  assign cols      = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: timestamp-based keypad/scan model checked every cycle, plus directed literals.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pins_of(input logic [3:0] c, input logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (k[ri*4+ci] && (c[ci] === 1'b0)) r[ri] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] colmask(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic int lowest(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 3;
  endfunction

  // Keypad physically pulls rows down through whichever column the DUT drives.
  assign rows = pins_of(cols, keys);

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 scan, 1 press debounce, 2 held, 3 release debounce; t = edge the mode began.
  int         e = 0;
  int         t = 0;
  int         base = 0;
  int         mode = 0;
  int         mcol = 0;
  int         mrow = 0;
  int         k = 0;
  int         col_pre = 0;
  logic [3:0] mcode = 4'h0;
  logic       mvalid = 1'b0;
  bit         m_init = 1'b0;
  logic [3:0] pins, seen;
  logic [3:0] h0 = 4'hF;
  logic [3:0] h1 = 4'hF;

  function automatic int cur_col();
    if (mode == 0) return (base + (e - t) / SD) % 4;
    return mcol;
  endfunction

  always @(posedge clk) begin
    col_pre = cur_col();
    pins = pins_of(colmask(col_pre), keys);
`ifdef SCAN_SYNC_EN
    seen = h1;
    h1 = h0;
    h0 = pins;
`else
    seen = pins;
`endif
    e++;
    mvalid = 1'b0;
    if (!reset) begin
      mode = 0; t = e; base = 0; mcol = 0; mrow = 0; mcode = 4'h0;
      h0 = 4'hF; h1 = 4'hF; m_init = 1'b1;
    end else if (m_init) begin
      k = e - 1 - t;
      case (mode)
        0: if ((k % SD) == SD - 1 && seen != 4'hF) begin
             mcol = col_pre; mrow = lowest(seen); mode = 1; t = e;
           end
        1: if (k == DB - 1) begin
             if (!seen[mrow]) begin
               mode = 2; t = e; mcode = kmap[mrow*4+mcol]; mvalid = 1'b1;
             end else begin
               mode = 0; t = e; base = (mcol + 1) % 4;
             end
           end
        2: if (seen[mrow]) begin mode = 3; t = e; end
        3: if (k == DB - 1) begin
             if (seen[mrow]) begin mode = 0; t = e; base = (mcol + 1) % 4; end
             else begin mode = 2; t = e; end
           end
        default: mode = 0;
      endcase
    end
    #1;
    if (m_init) begin
      chk("cols", cols, colmask(cur_col()));
      chk("key_code", key_code, mcode);
      chk("key_valid", {3'b000, key_valid}, {3'b000, mvalid});
      chk("key_held", {3'b000, key_held}, {3'b000, (mode >= 2)});
      if (key_valid) pulses++;
    end
  end

  task automatic wait_cols(input logic [3:0] target);
    for (int i = 0; i < 40 && cols == target; i++) @(negedge clk);
    for (int i = 0; i < 40 && cols != target; i++) @(negedge clk);
    chk("wait_cols", cols, target);
  endtask

  task automatic wait_held();
    for (int i = 0; i < 80 && !key_held; i++) @(negedge clk);
    chk("wait_held", {3'b000, key_held}, 4'h1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cols"}, cols, 4'b1110);
    chk({tag, "_code"}, key_code, 4'h0);
    chk({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
    chk({tag, "_held"}, {3'b000, key_held}, 4'h0);
  endtask

  logic [3:0] step_tbl [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int p0;
  logic [15:0] rk;

  initial begin
    // Reset and free-running column walk
    reset = 1'b0;
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (SD) @(negedge clk);
      chk("col_step", cols, step_tbl[i]);
    end

    // Key '5' held 40 cycles
    p0 = pulses;
    keys = 16'h0020;
    repeat (40) @(negedge clk);
    chk("k5_code", key_code, 4'h5);
    chk("k5_held", {3'b000, key_held}, 4'h1);
    chk("k5_cols", cols, 4'b1101);
    chk("k5_pulses", 4'(pulses - p0), 4'd1);
    keys = 16'h0000;
    repeat (30) @(negedge clk);
    chk("k5_rel_held", {3'b000, key_held}, 4'h0);

    // Short press rejected
    wait_cols(4'b1101);
    p0 = pulses;
    keys = 16'h0020;
    repeat (DB - 3) @(negedge clk);
    keys = 16'h0000;
    repeat (30) @(negedge clk);
    chk("short_pulses", 4'(pulses - p0), 4'd0);
    chk("short_code", key_code, 4'h5);

    // Second key while held, found after first is released
    p0 = pulses;
    keys = 16'h0020;
    wait_held();
    keys[15] = 1'b1;
    repeat (20) @(negedge clk);
    chk("two_key_pulses", 4'(pulses - p0), 4'd1);
    keys[5] = 1'b0;
    repeat (60) @(negedge clk);
    chk("kD_code", key_code, 4'hD);
    chk("kD_pulses", 4'(pulses - p0), 4'd2);
    chk("kD_held", {3'b000, key_held}, 4'h1);
    keys = 16'h0000;
    repeat (40) @(negedge clk);

    // Release bounce while held
    keys = 16'h0020;
    wait_held();
    p0 = pulses;
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    keys = 16'h0020;
    repeat (20) @(negedge clk);
    chk("bounce_held", {3'b000, key_held}, 4'h1);
    chk("bounce_pulses", 4'(pulses - p0), 4'd0);
    keys = 16'h0000;
    repeat (30) @(negedge clk);

    // Reset during press debounce, then during HELD
    wait_cols(4'b1101);
    keys = 16'h0020;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_dp");
    reset = 1'b1;
    wait_held();
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_held");
    reset = 1'b1;
    keys = 16'h0000;
    repeat (20) @(negedge clk);

    // Random presses, multi-key combinations, bounces and occasional resets
    for (int it = 0; it < 150; it++) begin
      rk = 16'h0000;
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) rk[$urandom_range(0, 15)] = 1'b1;
      keys = rk;
      repeat ($urandom_range(1, 40)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        keys = 16'h0000;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        keys = rk;
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      keys = 16'h0000;
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
